sha256_sched_ctrl: RTL and testbench

//   Initiator side of the SHA-256 compression-core interface. Accepts 512-bit message blocks,

---
 rtl/sha256_sched_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sha256_sched_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 schedule/control front end: block intake, W_t expansion, K_t ROM, core sequencing.
// Define SHA256_SCHED_ERR_EN to add proto_err for blk_first/open-message protocol violations.
module sha256_sched_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         digest_ack,
  output logic         init,
  output logic         ready,
  output logic         digest_update,
  output logic         done,
  output logic [31:0]  W_i,
  output logic [31:0]  K_i,
`ifdef SHA256_SCHED_ERR_EN
  output logic         proto_err,
`endif
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_t           state;
  logic             msg_open;
  logic             last_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      win [16];
  logic [31:0]      w_next;
  logic [5:0]       kidx;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] kconst(input logic [5:0] t);
    logic [31:0] k;
    case (t)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign kidx   = 6'(cnt);

  // Schedule/constant buses are only meaningful while the core is consuming a round.
  assign W_i  = ready ? win[0] : 32'h0;
  assign K_i  = ready ? kconst(kidx) : 32'h0;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      msg_open      <= 1'b0;
      last_q        <= 1'b0;
      cnt           <= '0;
      blk_ready     <= 1'b0;
      init          <= 1'b0;
      ready         <= 1'b0;
      digest_update <= 1'b0;
      done          <= 1'b0;
`ifdef SHA256_SCHED_ERR_EN
      proto_err     <= 1'b0;
`endif
      for (int i = 0; i < 16; i++) begin
        win[i] <= 32'h0;
      end
    end else begin
      init          <= 1'b0;
      digest_update <= 1'b0;
`ifdef SHA256_SCHED_ERR_EN
      proto_err     <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          blk_ready <= 1'b1;
          if (blk_valid && blk_ready) begin
            for (int i = 0; i < 16; i++) begin
              win[i] <= blk_data[511-32*i -: 32];
            end
            last_q    <= blk_last;
            blk_ready <= 1'b0;
`ifdef SHA256_SCHED_ERR_EN
            proto_err <= (blk_first == msg_open);
`endif
            // A stray first=0 with no open message still gets a fresh H load.
            if (blk_first || !msg_open) begin
              state <= S_INIT;
              init  <= 1'b1;
            end else begin
              state <= S_ROUND;
              ready <= 1'b1;
              cnt   <= '0;
            end
          end
        end
        S_INIT: begin
          msg_open <= 1'b1;
          state    <= S_ROUND;
          ready    <= 1'b1;
          cnt      <= '0;
        end
        S_ROUND: begin
          for (int i = 0; i < 15; i++) begin
            win[i] <= win[i+1];
          end
          win[15] <= w_next;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_RND) begin
            ready         <= 1'b0;
            digest_update <= 1'b1;
            state         <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (last_q) begin
            state    <= S_DONE;
            done     <= 1'b1;
            msg_open <= 1'b0;
          end else begin
            state     <= S_IDLE;
            blk_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (digest_ack) begin
            done      <= 1'b0;
            state     <= S_IDLE;
            blk_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Scoreboard bench for sha256_sched_ctrl with a behavioural compression core.
// Build with SHA256_SCHED_ERR_EN defined to also exercise proto_err.
module tb_sha256_sched_ctrl;

  localparam int ROUNDS = 64;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] DG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_2B =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic         digest_ack = 1'b0;
  logic         init, ready, digest_update, done, busy;
  logic [31:0]  W_i, K_i;
`ifdef SHA256_SCHED_ERR_EN
  logic         proto_err;
`endif

  sha256_sched_ctrl #(.ROUNDS(ROUNDS), .CNT_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data(blk_data),
    .blk_first(blk_first),
    .blk_last(blk_last),
    .digest_ack(digest_ack),
    .init(init),
    .ready(ready),
    .digest_update(digest_update),
    .done(done),
    .W_i(W_i),
    .K_i(K_i),
`ifdef SHA256_SCHED_ERR_EN
    .proto_err(proto_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct { int start; bit exp_init; } blk_exp_t;
  typedef struct {
    int burst; int rnd;
    bit chk_w; logic [31:0] w;
    bit chk_k; logic [31:0] k;
  } probe_t;
  typedef struct { int cyc; logic [255:0] dg; } dg_exp_t;

  blk_exp_t blk_q[$];
  probe_t   prb_q[$];
  dg_exp_t  dg_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Behavioural compression core driven by init/ready/digest_update.
  logic [31:0] H [8];
  logic [31:0] v [8];
  logic [31:0] t1, t2;
  int rnd = 0;
  int bursts = 0;
  int perr_cnt = 0;
  bit init_prev = 0;
  bit done_prev = 0;
  blk_exp_t be;
  probe_t   pb;
  dg_exp_t  de;

  always @(negedge clk) begin
    if (reset) begin
      rnd = 0;
      init_prev = 0;
      done_prev = 0;
    end else begin
      chk("onehot", 256'($countones({init, ready, digest_update, done}) <= 1), 1);
      if (init) begin
        H = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      end
      if (ready) begin
        if (rnd == 0) begin
          if (blk_q.size() == 0) begin
            chk("burst_unexpected", 1, 0);
          end else begin
            be = blk_q.pop_front();
            chk("burst_start", pcyc, be.start);
            chk("burst_init", init_prev, be.exp_init);
          end
          bursts++;
          v = H;
        end
        while (prb_q.size() > 0 && prb_q[0].burst == bursts - 1 &&
               prb_q[0].rnd == rnd) begin
          pb = prb_q.pop_front();
          if (pb.chk_w) chk($sformatf("W_r%0d", pb.rnd), W_i, pb.w);
          if (pb.chk_k) chk($sformatf("K_r%0d", pb.rnd), K_i, pb.k);
        end
        t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
             ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_i + W_i;
        t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
             ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
        v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        rnd++;
      end
      if (digest_update) begin
        chk("round_count", rnd, ROUNDS);
        for (int i = 0; i < 8; i++) H[i] = H[i] + v[i];
        rnd = 0;
      end
      if (done && !done_prev) begin
        if (dg_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          de = dg_q.pop_front();
          chk("done_cycle", pcyc, de.cyc);
          chk("digest", {H[0], H[1], H[2], H[3], H[4], H[5], H[6], H[7]}, de.dg);
        end
      end
`ifdef SHA256_SCHED_ERR_EN
      if (proto_err) perr_cnt++;
`endif
      init_prev = init;
      done_prev = done;
    end
  end

  int sent = 0;

  task automatic send(input logic [511:0] d, input bit first, input bit last,
                      input bit exp_init, input bit chk_done,
                      input logic [255:0] dg, input bit hold, output int p);
    int n;
    @(negedge clk);
    blk_data = d;
    blk_first = first;
    blk_last = last;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    p = pcyc;
    if (!blk_ready) begin
      chk("handshake_timeout", 0, 1);
      blk_valid = 1'b0;
    end else begin
      blk_q.push_back('{start: p + (exp_init ? 2 : 1), exp_init: exp_init});
      if (last && chk_done)
        dg_q.push_back('{cyc: p + (exp_init ? 67 : 66), dg: dg});
      sent++;
      @(posedge clk);
      #1;
      if (!hold) blk_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    chk("done_wait", done, 1);
  endtask

  task automatic ack();
    digest_ack = 1'b1;
    @(negedge clk);
    digest_ack = 1'b0;
    chk("ack_done_low", done, 0);
    chk("ack_blk_ready", blk_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, n, bad, rdy_seen, perr0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {init, ready, digest_update, done, busy, blk_ready, W_i, K_i}, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_blk_ready", blk_ready, 1);
    chk("idle_busy", busy, 0);

    // "abc" single block with schedule/constant probes
    prb_q.push_back('{sent, 0, 1, 32'h61626380, 1, 32'h428a2f98});
    prb_q.push_back('{sent, 16, 1, 32'h61626380, 0, 32'h0});
    prb_q.push_back('{sent, 17, 1, 32'h000f0000, 0, 32'h0});
    prb_q.push_back('{sent, 63, 0, 32'h0, 1, 32'hc67178f2});
    send(ABC, 1, 1, 1, 1, DG_ABC, 0, p);
    wait_done();
    chk("done_busy", busy, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!done || blk_ready) bad++;
    end
    chk("done_hold", bad, 0);
    ack();

    // digest_ack while idle is ignored
    digest_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack_ignored", {blk_ready, busy}, 2'b10);
    digest_ack = 1'b0;

    // two-block message, one init
    send(B1, 1, 0, 1, 0, '0, 0, p);
    send(B2, 0, 1, 0, 1, DG_2B, 0, p);
    wait_done();
    ack();

    // blk_valid held with changing data during processing
    send(ABC, 1, 1, 1, 1, DG_ABC, 1, p);
    blk_data = {512{1'b1}};
    rdy_seen = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (blk_ready) rdy_seen++;
      n++;
    end while (!done && n < 200);
    chk("held_done", done, 1);
    chk("held_no_ready", rdy_seen, 0);
    blk_valid = 1'b0;
    ack();

    // reset at round 30, then first=0 block must take init
    send(ABC, 1, 1, 1, 0, '0, 0, p);
    n = 0;
    while (pcyc != p + 32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("round30_ready", ready, 1);
    #2 reset = 1'b1;
    #1 chk("midreset_outputs",
           {init, ready, digest_update, done, busy, blk_ready, W_i, K_i}, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    perr0 = perr_cnt;
    send(ABC, 0, 1, 1, 1, DG_ABC, 0, p);
    wait_done();
`ifdef SHA256_SCHED_ERR_EN
    chk("perr_first0", perr_cnt - perr0, 1);
`endif
    ack();

    // first=1 mid-message abandons and restarts
    perr0 = perr_cnt;
    send(B1, 1, 0, 1, 0, '0, 0, p);
    send(ABC, 1, 1, 1, 1, DG_ABC, 0, p);
    wait_done();
`ifdef SHA256_SCHED_ERR_EN
    chk("perr_restart", perr_cnt - perr0, 1);
`endif
    ack();

    repeat (5) @(negedge clk);
    chk("queues_empty", blk_q.size() + dg_q.size() + prb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
